// File: rtl/decode_stage_pkg.sv
// Shared ISA constants and decoded-control record for the decode stage.
// The helper maps an opcode to the control fields that do not depend on operand fields.
package decode_stage_pkg;

  localparam logic [3:0] INST_HALT = 4'h0;
  localparam logic [3:0] INST_LW   = 4'h1;
  localparam logic [3:0] INST_JMP  = 4'h2;
  localparam logic [3:0] INST_JE   = 4'h3;
  localparam logic [3:0] INST_JNE  = 4'h4;
  localparam logic [3:0] INST_ADD  = 4'h5;
  localparam logic [3:0] INST_SUB  = 4'h6;
  localparam logic [3:0] INST_XOR  = 4'h7;
  localparam logic [3:0] INST_CMP  = 4'h8;
  localparam logic [3:0] INST_LIMM = 4'h9;
  localparam logic [3:0] INST_MOV  = 4'hA;
  localparam logic [3:0] INST_SW   = 4'hB;
  localparam logic [3:0] INST_INC  = 4'hC;
  localparam logic [3:0] INST_SPEC = 4'hD;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_XOR   = 4'h3;
  localparam logic [3:0] OP_INC   = 4'h4;
  localparam logic [3:0] OP_PASSB = 4'h5;
  localparam logic [3:0] OP_SPEC  = 4'h6;

  typedef enum logic [1:0] {
    SEL_NON = 2'b00,
    SEL_REG = 2'b01,
    SEL_MEM = 2'b10,
    SEL_IMM = 2'b11
  } sel_e;

  typedef enum logic [2:0] {
    PCSEL_INC = 3'b000,
    PCSEL_JMP = 3'b001,
    PCSEL_JE  = 3'b010,
    PCSEL_JNE = 3'b011,
    PCSEL_HLT = 3'b100
  } pc_sel_e;

  typedef struct packed {
    sel_e       a_sel;
    sel_e       b_sel;
    logic [3:0] alu_op;
    pc_sel_e    pc_sel;
    logic       reg_w_en;
    logic       mem_w_en;
    logic       cmp_write;
    logic       illegal;
  } dec_ctrl_t;

  function automatic dec_ctrl_t ctrl_of(input logic [3:0] opc);
    dec_ctrl_t c;
    c = '0;
    case (opc)
      INST_ADD, INST_SUB, INST_XOR, INST_SPEC: begin
        c.a_sel    = SEL_REG;
        c.b_sel    = SEL_REG;
        c.reg_w_en = 1'b1;
        c.alu_op   = (opc == INST_ADD) ? OP_ADD :
                     (opc == INST_SUB) ? OP_SUB :
                     (opc == INST_XOR) ? OP_XOR : OP_SPEC;
      end
      INST_CMP: begin
        c.a_sel     = SEL_REG;
        c.b_sel     = SEL_REG;
        c.alu_op    = OP_SUB;
        c.cmp_write = 1'b1;
      end
      INST_SW: begin
        c.a_sel    = SEL_REG;
        c.b_sel    = SEL_REG;
        c.alu_op   = OP_PASSB;
        c.mem_w_en = 1'b1;
      end
      INST_INC: begin
        c.a_sel    = SEL_REG;
        c.alu_op   = OP_INC;
        c.reg_w_en = 1'b1;
      end
      INST_MOV, INST_LW, INST_LIMM: begin
        c.b_sel    = (opc == INST_MOV) ? SEL_REG :
                     (opc == INST_LW)  ? SEL_MEM : SEL_IMM;
        c.alu_op   = OP_PASSB;
        c.reg_w_en = 1'b1;
      end
      INST_JMP:  c.pc_sel = PCSEL_JMP;
      INST_JE:   c.pc_sel = PCSEL_JE;
      INST_JNE:  c.pc_sel = PCSEL_JNE;
      INST_HALT: c.pc_sel = PCSEL_HLT;
      default:   c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder: opcode controls plus operand fields.
// Fields not consumed by an instruction are forced to zero.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int INST_W = 16,
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int REG_AW = 3
) (
  input  logic [INST_W-1:0] inst,
  output dec_ctrl_t         ctrl,
  output logic [DATA_W-1:0] imm_a,
  output logic [DATA_W-1:0] imm_b,
  output logic [REG_AW-1:0] reg_a,
  output logic [REG_AW-1:0] reg_b,
  output logic [REG_AW-1:0] reg_w,
  output logic [PC_W-1:0]   jump_target
);

  localparam int FIELD_W = (INST_W - 4) / 2;
  localparam int TGT_W   = INST_W - 4;

  logic [3:0]         opc;
  logic [FIELD_W-1:0] lo;
  logic [REG_AW-1:0]  hi_idx;
  logic [REG_AW-1:0]  lo_idx;
  logic [TGT_W-1:0]   tgt;
  logic [DATA_W-1:0]  lo_ext;
  logic [PC_W-1:0]    tgt_ext;
  logic               use_lo;

  assign opc    = inst[INST_W-1 -: 4];
  assign lo     = inst[FIELD_W-1:0];
  assign hi_idx = inst[FIELD_W +: REG_AW];
  assign lo_idx = lo[REG_AW-1:0];
  assign tgt    = inst[TGT_W-1:0];
  // INC is the only instruction that reads and writes the low field register
  assign use_lo = (opc == INST_INC);

  if (DATA_W > FIELD_W) begin : g_imm_wide
    assign lo_ext = {{(DATA_W-FIELD_W){1'b0}}, lo};
  end else begin : g_imm_narrow
    assign lo_ext = lo[DATA_W-1:0];
  end

  if (PC_W > TGT_W) begin : g_tgt_wide
    assign tgt_ext = {{(PC_W-TGT_W){1'b0}}, tgt};
  end else begin : g_tgt_narrow
    assign tgt_ext = tgt[PC_W-1:0];
  end

  always_comb begin
    dec_ctrl_t c;
    c           = ctrl_of(opc);
    ctrl        = c;
    imm_a       = '0;
    imm_b       = (c.b_sel == SEL_IMM) ? lo_ext : '0;
    reg_a       = (c.a_sel == SEL_REG) ? (use_lo ? lo_idx : hi_idx) : '0;
    reg_b       = (c.b_sel == SEL_REG || c.b_sel == SEL_MEM) ? lo_idx : '0;
    reg_w       = c.reg_w_en ? (use_lo ? lo_idx : hi_idx) : '0;
    jump_target = (c.pc_sel == PCSEL_JMP || c.pc_sel == PCSEL_JE ||
                   c.pc_sel == PCSEL_JNE) ? tgt_ext : '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready on both sides, a register
// scoreboard for RAW/WAW hazards, and halt/flush handling.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INST_W = 16,
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_a,
  output logic [DATA_W-1:0] imm_b,
  output logic [REG_AW-1:0] reg_a,
  output logic [REG_AW-1:0] reg_b,
  output logic [REG_AW-1:0] reg_w,
  output logic [1:0]        a_sel,
  output logic [1:0]        b_sel,
  output logic [3:0]        alu_op,
  output logic [2:0]        pc_sel,
  output logic [PC_W-1:0]   jump_target,
  output logic              reg_w_en,
  output logic              mem_w_en,
  output logic              cmp_write,
  output logic              illegal,
  output logic              halted,
  output logic              stall
);

  localparam int NUM_REGS = 2 ** REG_AW;

  dec_ctrl_t         dec_ctrl;
  logic [DATA_W-1:0] dec_imm_a, dec_imm_b;
  logic [REG_AW-1:0] dec_reg_a, dec_reg_b, dec_reg_w;
  logic [PC_W-1:0]   dec_jump_target;

  dec_ctrl_t         ctrl_reg, ctrl_next;
  logic [DATA_W-1:0] imm_a_reg, imm_a_next, imm_b_reg, imm_b_next;
  logic [REG_AW-1:0] reg_a_reg, reg_a_next, reg_b_reg, reg_b_next;
  logic [REG_AW-1:0] reg_w_reg, reg_w_next;
  logic [PC_W-1:0]   jump_target_reg, jump_target_next;
  logic              out_valid_reg, out_valid_next;
  logic              halted_reg, halted_next;
  logic [NUM_REGS-1:0] sb_reg, sb_next, sb_set, sb_clr;

  logic hazard;
  logic accept;

  decode_comb #(
    .INST_W (INST_W),
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .REG_AW (REG_AW)
  ) u_decode_comb (
    .inst        (in_inst),
    .ctrl        (dec_ctrl),
    .imm_a       (dec_imm_a),
    .imm_b       (dec_imm_b),
    .reg_a       (dec_reg_a),
    .reg_b       (dec_reg_b),
    .reg_w       (dec_reg_w),
    .jump_target (dec_jump_target)
  );

  // Hazard looks only at the registered scoreboard; a same-cycle writeback is not bypassed
  assign hazard = in_valid &&
                  ((dec_ctrl.a_sel == SEL_REG && sb_reg[dec_reg_a]) ||
                   (dec_ctrl.b_sel == SEL_REG && sb_reg[dec_reg_b]) ||
                   (dec_ctrl.reg_w_en && sb_reg[dec_reg_w]));

  assign in_ready = rst && !halted_reg && !flush && !hazard &&
                    (!out_valid_reg || out_ready);
  assign stall    = rst && in_valid && !in_ready;
  assign accept   = in_valid && in_ready;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    assign sb_clr[gi] = (wb_valid && wb_reg == REG_AW'(gi)) ||
                        (flush && out_valid_reg && ctrl_reg.reg_w_en &&
                         reg_w_reg == REG_AW'(gi));
    assign sb_set[gi] = accept && dec_ctrl.reg_w_en && dec_reg_w == REG_AW'(gi);
    // A set from a new accept overrides a retire of the same register
    assign sb_next[gi] = sb_set[gi] | (sb_reg[gi] & ~sb_clr[gi]);
  end

  always_comb begin
    ctrl_next        = ctrl_reg;
    imm_a_next       = imm_a_reg;
    imm_b_next       = imm_b_reg;
    reg_a_next       = reg_a_reg;
    reg_b_next       = reg_b_reg;
    reg_w_next       = reg_w_reg;
    jump_target_next = jump_target_reg;
    out_valid_next   = out_valid_reg;
    halted_next      = halted_reg;
    if (accept) begin
      ctrl_next        = dec_ctrl;
      imm_a_next       = dec_imm_a;
      imm_b_next       = dec_imm_b;
      reg_a_next       = dec_reg_a;
      reg_b_next       = dec_reg_b;
      reg_w_next       = dec_reg_w;
      jump_target_next = dec_jump_target;
      out_valid_next   = 1'b1;
      if (dec_ctrl.pc_sel == PCSEL_HLT) halted_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
    if (flush) begin
      out_valid_next = 1'b0;
      halted_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_reg        <= '0;
      imm_a_reg       <= '0;
      imm_b_reg       <= '0;
      reg_a_reg       <= '0;
      reg_b_reg       <= '0;
      reg_w_reg       <= '0;
      jump_target_reg <= '0;
      out_valid_reg   <= 1'b0;
      halted_reg      <= 1'b0;
      sb_reg          <= '0;
    end else begin
      ctrl_reg        <= ctrl_next;
      imm_a_reg       <= imm_a_next;
      imm_b_reg       <= imm_b_next;
      reg_a_reg       <= reg_a_next;
      reg_b_reg       <= reg_b_next;
      reg_w_reg       <= reg_w_next;
      jump_target_reg <= jump_target_next;
      out_valid_reg   <= out_valid_next;
      halted_reg      <= halted_next;
      sb_reg          <= sb_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign halted      = halted_reg;
  assign imm_a       = imm_a_reg;
  assign imm_b       = imm_b_reg;
  assign reg_a       = reg_a_reg;
  assign reg_b       = reg_b_reg;
  assign reg_w       = reg_w_reg;
  assign a_sel       = ctrl_reg.a_sel;
  assign b_sel       = ctrl_reg.b_sel;
  assign alu_op      = ctrl_reg.alu_op;
  assign pc_sel      = ctrl_reg.pc_sel;
  assign jump_target = jump_target_reg;
  assign reg_w_en    = ctrl_reg.reg_w_en;
  assign mem_w_en    = ctrl_reg.mem_w_en;
  assign cmp_write   = ctrl_reg.cmp_write;
  assign illegal     = ctrl_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of instructions with expected
// decode records, scoreboard queue, and hand sequences for hazard/halt/flush.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [15:0] imm_a;
    logic [15:0] imm_b;
    logic [2:0]  reg_a;
    logic [2:0]  reg_b;
    logic [2:0]  reg_w;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [3:0]  alu_op;
    logic [2:0]  pc_sel;
    logic [15:0] jt;
    logic        we;
    logic        me;
    logic        cw;
    logic        il;
  } exp_t;

  typedef struct {
    logic [15:0] inst;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_inst = '0;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_reg = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] imm_a, imm_b, jump_target;
  logic [2:0]  reg_a, reg_b, reg_w, pc_sel;
  logic [1:0]  a_sel, b_sel;
  logic [3:0]  alu_op;
  logic        reg_w_en, mem_w_en, cmp_write, illegal, halted, stall;

  int   n_vec = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t cur_exp;
  vec_t vecs[14];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .flush(flush), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .out_valid(out_valid), .out_ready(out_ready), .imm_a(imm_a), .imm_b(imm_b),
    .reg_a(reg_a), .reg_b(reg_b), .reg_w(reg_w), .a_sel(a_sel), .b_sel(b_sel),
    .alu_op(alu_op), .pc_sel(pc_sel), .jump_target(jump_target),
    .reg_w_en(reg_w_en), .mem_w_en(mem_w_en), .cmp_write(cmp_write),
    .illegal(illegal), .halted(halted), .stall(stall)
  );

  function automatic exp_t mk(logic [15:0] ib, logic [2:0] ra, logic [2:0] rb,
                              logic [2:0] rw, logic [1:0] asel, logic [1:0] bsel,
                              logic [3:0] op, logic [2:0] pc, logic [15:0] jt,
                              logic we, logic me, logic cw, logic il);
    exp_t e;
    e.imm_a = '0; e.imm_b = ib; e.reg_a = ra; e.reg_b = rb; e.reg_w = rw;
    e.a_sel = asel; e.b_sel = bsel; e.alu_op = op; e.pc_sel = pc; e.jt = jt;
    e.we = we; e.me = me; e.cw = cw; e.il = il;
    return e;
  endfunction

  function automatic exp_t dut_rec();
    exp_t e;
    e.imm_a = imm_a; e.imm_b = imm_b; e.reg_a = reg_a; e.reg_b = reg_b;
    e.reg_w = reg_w; e.a_sel = a_sel; e.b_sel = b_sel; e.alu_op = alu_op;
    e.pc_sel = pc_sel; e.jt = jump_target; e.we = reg_w_en; e.me = mem_w_en;
    e.cw = cmp_write; e.il = illegal;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_rec(input string name, input exp_t act, input exp_t req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("out  rec=%h ok", act);
    end
  endtask

  // Called at a negedge with inputs set; accounts for handshakes that the next posedge takes.
  task automatic step(output bit fired);
    #1;
    fired = in_valid && in_ready;
    if (fired) begin
      q.push_back(cur_exp);
      $display("in   inst=%h accepted", in_inst);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check_rec("out_rec", dut_rec(), e);
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] inst, input exp_t e);
    bit f;
    f = 1'b0;
    in_inst = inst; in_valid = 1'b1; cur_exp = e;
    for (int i = 0; i < 20 && !f; i++) step(f);
    if (!f) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(f);
    if (q.size() != 0) check("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic wb(input logic [2:0] r);
    bit f;
    wb_valid = 1'b1; wb_reg = r;
    step(f);
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   f;
    exp_t e_add, e_mov, e_mov4, e_limm, e_halt, e_xor;
    e_add  = mk(16'h0, 3, 2, 3, 2'b01, 2'b01, OP_ADD,   3'b000, 16'h0, 1, 0, 0, 0);
    e_mov  = mk(16'h0, 0, 3, 1, 2'b00, 2'b01, OP_PASSB, 3'b000, 16'h0, 1, 0, 0, 0);
    e_mov4 = mk(16'h0, 0, 4, 4, 2'b00, 2'b01, OP_PASSB, 3'b000, 16'h0, 1, 0, 0, 0);
    e_limm = mk(16'h5, 0, 0, 4, 2'b00, 2'b11, OP_PASSB, 3'b000, 16'h0, 1, 0, 0, 0);
    e_halt = mk(16'h0, 0, 0, 0, 2'b00, 2'b00, OP_NOP,   3'b100, 16'h0, 0, 0, 0, 0);
    e_xor  = mk(16'h0, 1, 7, 1, 2'b01, 2'b01, OP_XOR,   3'b000, 16'h0, 1, 0, 0, 0);

    vecs[0]  = '{16'h50CA, e_add};
    vecs[1]  = '{16'h6F46, mk(16'h0, 5, 6, 5, 2'b01, 2'b01, OP_SUB, 3'b000, 16'h0, 1, 0, 0, 0)};
    vecs[2]  = '{16'h7047, e_xor};
    vecs[3]  = '{16'h8084, mk(16'h0, 2, 4, 0, 2'b01, 2'b01, OP_SUB, 3'b000, 16'h0, 0, 0, 1, 0)};
    vecs[4]  = '{16'hB181, mk(16'h0, 6, 1, 0, 2'b01, 2'b01, OP_PASSB, 3'b000, 16'h0, 0, 1, 0, 0)};
    vecs[5]  = '{16'hC005, mk(16'h0, 5, 0, 5, 2'b01, 2'b00, OP_INC, 3'b000, 16'h0, 1, 0, 0, 0)};
    vecs[6]  = '{16'h1083, mk(16'h0, 0, 3, 2, 2'b00, 2'b10, OP_PASSB, 3'b000, 16'h0, 1, 0, 0, 0)};
    vecs[7]  = '{16'h912A, mk(16'h2A, 0, 0, 4, 2'b00, 2'b11, OP_PASSB, 3'b000, 16'h0, 1, 0, 0, 0)};
    vecs[8]  = '{16'h2ABC, mk(16'h0, 0, 0, 0, 2'b00, 2'b00, OP_NOP, 3'b001, 16'h0ABC, 0, 0, 0, 0)};
    vecs[9]  = '{16'h3123, mk(16'h0, 0, 0, 0, 2'b00, 2'b00, OP_NOP, 3'b010, 16'h0123, 0, 0, 0, 0)};
    vecs[10] = '{16'h4FFF, mk(16'h0, 0, 0, 0, 2'b00, 2'b00, OP_NOP, 3'b011, 16'h0FFF, 0, 0, 0, 0)};
    vecs[11] = '{16'hF123, mk(16'h0, 0, 0, 0, 2'b00, 2'b00, OP_NOP, 3'b000, 16'h0, 0, 0, 0, 1)};
    vecs[12] = '{16'hE7FF, mk(16'h0, 0, 0, 0, 2'b00, 2'b00, OP_NOP, 3'b000, 16'h0, 0, 0, 0, 1)};
    vecs[13] = '{16'hD1C0, mk(16'h0, 7, 0, 7, 2'b01, 2'b01, OP_SPEC, 3'b000, 16'h0, 1, 0, 0, 0)};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check_rec("rst_rec", dut_rec(), '0);
    check("rst_halted", halted, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_rst_ready", in_ready, 1);
    @(negedge clk);

    // Decode table
    foreach (vecs[i]) begin
      send(vecs[i].inst, vecs[i].exp);
      drain();
      if (vecs[i].exp.we) wb(vecs[i].exp.reg_w);
    end

    // RAW hazard; ADD accepted alongside a retire of r3 so the set must win
    in_inst = 16'h50CA; in_valid = 1'b1; cur_exp = e_add;
    wb_valid = 1'b1; wb_reg = 3'd3;
    step(f);
    check("add_accept", f, 1);
    wb_valid = 1'b0;
    in_inst = 16'hA043; cur_exp = e_mov;
    #1 check("raw_stall", stall, 1);
    check("raw_in_ready", in_ready, 0);
    step(f);
    check("raw_hold", f, 0);
    wb_valid = 1'b1; wb_reg = 3'd3;
    #1 check("raw_no_bypass", stall, 1);
    step(f);
    check("raw_wb_cycle", f, 0);
    wb_valid = 1'b0;
    #1 check("raw_released", in_ready, 1);
    step(f);
    check("mov_accept", f, 1);
    in_valid = 1'b0;
    drain();
    wb(3'd1);

    // Backpressure with a second instruction waiting
    out_ready = 1'b0;
    send(16'h9105, e_limm);
    in_inst = 16'h7047; in_valid = 1'b1; cur_exp = e_xor;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_imm_b", imm_b, 16'h5);
      check("bp_b_sel", b_sel, 2'b11);
      check("bp_in_ready", in_ready, 0);
      step(f);
    end
    out_ready = 1'b1;
    #1 check("bp_release", in_ready, 1);
    step(f);
    check("bp_xor_accept", f, 1);
    in_valid = 1'b0;
    drain();
    wb(3'd4);
    wb(3'd1);

    // HALT, then flush, then flush of a held LIMM
    send(16'h0000, e_halt);
    in_inst = 16'h9105; in_valid = 1'b1; cur_exp = e_limm;
    #1 check("halted_set", halted, 1);
    check("halt_in_ready", in_ready, 0);
    check("halt_stall", stall, 1);
    step(f);
    #1 check("halt_once", out_valid, 0);
    step(f);
    check("halt_no_accept", f, 0);
    flush = 1'b1;
    step(f);
    check("flush_no_accept", f, 0);
    flush = 1'b0;
    #1 check("halt_cleared", halted, 0);
    out_ready = 1'b0;
    step(f);
    check("limm_accept", f, 1);
    in_inst = 16'hA104; cur_exp = e_mov4;
    #1 check("waw_stall", stall, 1);
    in_valid = 1'b0;
    flush = 1'b1;
    step(f);
    flush = 1'b0;
    if (q.size() != 0) void'(q.pop_back());
    #1 check("flush_drop", out_valid, 0);
    in_valid = 1'b1;
    #1 check("flush_sb_clear", in_ready, 1);
    out_ready = 1'b1;
    step(f);
    check("mov4_accept", f, 1);
    in_valid = 1'b0;
    drain();
    wb(3'd4);

    // Asynchronous reset mid-stream with a held output and sb[3] set
    out_ready = 1'b0;
    send(16'h50CA, e_add);
    #1 check("pre_rst_valid", out_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check_rec("async_rst_rec", dut_rec(), '0);
    check("async_rst_ready", in_ready, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    in_inst = 16'hA043; in_valid = 1'b1;
    #1 check("rst_sb_clear", in_ready, 1);
    check("rst_no_stall", stall, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction decode stage: one pipeline register between fetch and execute, with valid/ready handshakes on both sides.
- Decodes the 4-bit-opcode ISA (HALT..SPEC) into operand-select, ALU, writeback, memory, compare and PC controls.
- Adds a register scoreboard that stalls RAW/WAW hazards until writeback, plus flush and halt handling.
- Widths of data, PC, instruction and register index are parameters.

Parameters:
- INST_W, 16, instruction width; opcode = in_inst[INST_W-1 -: 4]; FIELD_W = (INST_W-4)/2.
- DATA_W, 16, width of imm_a/imm_b; immediates zero-extended.
- PC_W, 16, width of jump_target; target = in_inst[INST_W-5:0] zero-extended/truncated.
- REG_AW, 3, register index width; NUM_REGS = 2**REG_AW; REG_AW <= FIELD_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1 / 1  fetch handshake.
- in_inst  in  INST_W  instruction.
- flush  in  1  discard held instruction, clear halt.
- wb_valid / wb_reg  in / in  1 / REG_AW  writeback retire of a register.
- out_valid / out_ready  out / in  1 / 1  execute handshake.
- imm_a, imm_b  out  DATA_W  immediate operands.
- reg_a, reg_b, reg_w  out  REG_AW  register indices.
- a_sel, b_sel  out  2  NON=00, REG=01, MEM=10, IMM=11.
- alu_op  out  4  ALU opcode (shared alu constants).
- pc_sel  out  3  INC=000, JMP=001, JE=010, JNE=011, HLT=100.
- jump_target  out  PC_W  branch target.
- reg_w_en, mem_w_en, cmp_write, illegal  out  1  control flags.
- halted, stall  out  1  status.

Behaviour:
- Reset (rst=0, async): every output 0, out_valid=0, scoreboard all clear, halted=0.
- Field split: hi = in_inst[2*FIELD_W-1:FIELD_W], lo = in_inst[FIELD_W-1:0]; register indices = low REG_AW bits of the field.
- Decode table:
  - ADD/SUB/XOR/SPEC: A=REG(hi), B=REG(lo), W=hi.
  - CMP: A=REG(hi), B=REG(lo), cmp_write=1, no W.
  - SW: A=REG(hi), B=REG(lo), mem_w_en=1, alu B.
  - INC: A=REG(lo), W=lo.
  - MOV: B=REG(lo), W=hi, alu B.
  - LW: B=MEM(lo), W=hi, alu B.
  - LIMM: B=IMM(lo), W=hi, alu B.
  - JMP/JE/JNE: jump_target set, pc_sel JMP/JE/JNE.
  - HALT: pc_sel HLT.
  - Opcodes 1110/1111: NOP, all enables 0, illegal=1.
  - Unused fields are 0.
- Hazard: comb = in_valid and (sb[src] for each REG-selected source, or sb[dst] when reg_w_en). Checked against registered scoreboard only (no same-cycle wb bypass).
- in_ready = !halted and !flush and !hazard and (!out_valid or out_ready).
- stall = in_valid and !in_ready.
- Accept (in_valid and in_ready): next cycle outputs hold the decode, out_valid=1, sb[reg_w] set if reg_w_en. Latency 1 cycle.
- Hold: out_valid and !out_ready keeps every output stable. Output drained with no accept → out_valid=0, fields keep their last value.
- Scoreboard update order per cycle: clear sb[wb_reg] on wb_valid, then set on accept. Same register in both → set wins.
- HALT accepted → halted=1 from the next cycle, in_ready=0 thereafter. The HALT itself is still presented on the output.
- flush:
  - Next cycle out_valid=0, halted=0.
  - If out_valid and reg_w_en, clear sb[reg_w] of the discarded instruction.
  - No accept in the flush cycle; wb_valid is still applied.
- wb_valid on a register with sb clear: no effect.

Decomposition:
- Shared package: INST_* opcodes, SEL_*, PCSEL_*, OP_* alu codes, and a decode-record struct (all output fields).
- Sub-module: decode_comb, a pure combinational function from instruction to decode record.
- Scoreboard, handshake and halt/flush logic stay in decode_stage.

Test Plan:
- Reset mid-stream with out_valid=1 and sb[3] set → all outputs 0 immediately; after release in_ready=1 and sb clear.
- ADD 0x50CA (hi=3, lo=2), out_ready=1 → next cycle out_valid=1, reg_a=3, reg_b=2, reg_w=3, a_sel=b_sel=01, reg_w_en=1, alu_op=OP_ADD.
- RAW hazard:
  - ADD r3,r2 then MOV 0xA043 (W=1, src lo=3) → MOV stalls (stall=1, in_ready=0).
  - wb_valid with wb_reg=3 → MOV accepted in the following cycle.
- Backpressure: out_ready=0 for 3 cycles with LIMM 0x9105 waiting → outputs stable, imm_b=5, b_sel=11; accept only after out_ready=1.
- HALT 0x0000 then further valid instructions → pc_sel=100 presented once, halted=1, in_ready=0; flush → halted=0, flushed LIMM's sb bit cleared.
- Illegal 0xF123 → illegal=1, all enables 0. JMP 0x2ABC with PC_W=16 → jump_target=0x0ABC, pc_sel=001.
